// File: rtl/ysyx_23060124_mem_arbiter.sv
// Purpose : shares one data-memory port between the IFU (read-only) and the LSU (read/write).
//           One request is in flight at a time, and round robin breaks ties between the two.
// Latency : accept at N, mem_req_valid at N+1, requester rsp pulse one cycle after mem_rsp_valid.
// Backpr. : upstream ready is asserted only in IDLE and only for the granted requester; the
//           request is held stable on mem_* until mem_req_ready, and WAIT times out after TIMEOUT cycles.
// Ports   : i_clk/i_rst_n (synchronous, active-high); ifu_req/rsp (read channel);
//           lsu_req/rsp (read/write channel); mem_req/rsp (downstream single-beat port).
module ysyx_23060124_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int STRB_W = DATA_W / 8;
  // WAIT is left after TIMEOUT cycles, so the last cycle that may still take a response
  // is the one where the counter holds TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = IFU, 1 = LSU
  logic                owner_q, owner_d;            // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

  logic grant_lsu;
  logic accept;
  logic rsp_hit;
  logic timeout_hit;

  // On a tie, the LSU wins whenever the IFU held the previous grant.
  assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
  assign accept      = ifu_req_ready || lsu_req_ready;
  // A response arriving in the same cycle as the timeout still takes priority.
  assign rsp_hit     = (state_q == ST_WAIT) && mem_rsp_valid;
  assign timeout_hit = (state_q == ST_WAIT) && !mem_rsp_valid && (cnt_q >= TO_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                  state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready)           state_d = ST_WAIT;
      ST_WAIT: if (rsp_hit || timeout_hit)  state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. These are gated during reset so that nothing is accepted or issued
  // in a reset cycle.
  always_comb begin
    ifu_req_ready = (state_q == ST_IDLE) && !i_rst_n && ifu_req_valid && !grant_lsu;
    lsu_req_ready = (state_q == ST_IDLE) && !i_rst_n && grant_lsu;
    mem_req_valid = (state_q == ST_REQ) && !i_rst_n;
  end

  // Datapath next values
  always_comb begin
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    cnt_d           = cnt_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_err_d   = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_err_d   = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;

    if (accept) begin
      owner_d      = lsu_req_ready;
      last_grant_d = lsu_req_ready;
      addr_d       = lsu_req_ready ? lsu_addr  : ifu_addr;
      wen_d        = lsu_req_ready && lsu_wen;
      wdata_d      = lsu_req_ready ? lsu_wdata : '0;
      wstrb_d      = lsu_req_ready ? lsu_wstrb : '0;
    end

    if ((state_q == ST_REQ) && mem_req_ready) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    if (rsp_hit || timeout_hit) begin
      if (owner_q) begin
        lsu_rsp_valid_d = 1'b1;
        lsu_rsp_err_d   = timeout_hit;
        lsu_rdata_d     = rsp_hit ? mem_rdata : '0;
      end else begin
        ifu_rsp_valid_d = 1'b1;
        ifu_rsp_err_d   = timeout_hit;
        ifu_rdata_d     = rsp_hit ? mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      last_grant_q    <= 1'b0;
      owner_q         <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      cnt_q           <= 16'd0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      lsu_rdata_q     <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      cnt_q           <= cnt_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      ifu_rdata_q     <= ifu_rdata_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
      lsu_rdata_q     <= lsu_rdata_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule
